// File: rtl/fadd_sub_sched.sv
// rtl/fadd_sub_sched.sv - round-robin arbiter and stage sequencer for the shared FP add/sub datapath
module fadd_sub_sched #(
    parameter int LAT   = 3,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [TAG_W-1:0] i_req0_tag,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [TAG_W-1:0] i_req1_tag,
    output logic             o_dp_load,
    output logic             o_dp_sel,
    output logic [LAT-1:0]   o_dp_stage_en,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic             o_rsp_id,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    localparam int CNT_W = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr_ptr;
    logic             r_owner;
    logic [TAG_W-1:0] r_tag;

    logic w_arb_ok;
    logic w_grant0;
    logic w_grant1;
    logic w_load;
    logic w_rsp_hs;

    // Reset and flush both mask grants so no handshake is lost in those cycles.
    assign w_arb_ok = (r_state == S_IDLE) && !i_flush && !i_reset;
    assign w_grant0 = w_arb_ok && i_req0_valid && (!i_req1_valid || !r_rr_ptr);
    assign w_grant1 = w_arb_ok && i_req1_valid && (!i_req0_valid ||  r_rr_ptr);
    assign w_load   = w_grant0 || w_grant1;

    assign o_req0_ready  = w_grant0;
    assign o_req1_ready  = w_grant1;
    assign o_dp_load     = w_load;
    // The operand mux must already point at the winner during the load cycle.
    assign o_dp_sel      = w_load ? w_grant1 : r_owner;
    assign o_dp_stage_en = (r_state == S_RUN && !i_flush) ? (LAT'(1) << r_cnt) : '0;
    assign o_rsp_valid   = (r_state == S_DONE) && !i_flush;
    assign o_rsp_id      = r_owner;
    assign o_rsp_tag     = r_tag;
    assign o_busy        = (r_state != S_IDLE);

    assign w_rsp_hs = o_rsp_valid && i_rsp_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rr_ptr <= 1'b0;
            r_owner  <= 1'b0;
            r_tag    <= '0;
        end else if (i_flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_owner <= w_grant1;
                        r_tag   <= w_grant1 ? i_req1_tag : i_req0_tag;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_rsp_hs) begin
                        r_state  <= S_IDLE;
                        r_rr_ptr <= ~r_owner;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_sub_sched.sv
// tb/tb_fadd_sub_sched.sv - directed self-checking bench for fadd_sub_sched
module tb_fadd_sub_sched;

    localparam int LAT   = 3;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             req0_valid;
    logic             req0_ready;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [TAG_W-1:0] req1_tag;
    logic             dp_load;
    logic             dp_sel;
    logic [LAT-1:0]   dp_stage_en;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fadd_sub_sched #(.LAT(LAT), .TAG_W(TAG_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_flush       (flush),
        .i_req0_valid  (req0_valid),
        .o_req0_ready  (req0_ready),
        .i_req0_tag    (req0_tag),
        .i_req1_valid  (req1_valid),
        .o_req1_ready  (req1_ready),
        .i_req1_tag    (req1_tag),
        .o_dp_load     (dp_load),
        .o_dp_sel      (dp_sel),
        .o_dp_stage_en (dp_stage_en),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_id      (rsp_id),
        .o_rsp_tag     (rsp_tag),
        .o_busy        (busy)
    );

    // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_tag = '0; req1_tag = '0; rsp_ready = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        mid();
        checks++;
        if ({req0_ready, req1_ready, dp_load, dp_sel, dp_stage_en, rsp_valid, rsp_id, rsp_tag, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {req0_ready, req1_ready, dp_load, dp_sel, dp_stage_en, rsp_valid, rsp_id, rsp_tag, busy});
        end
        cyc();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_tag = 4'd5; rsp_ready = 1'b1;
        mid();
        checks++;
        if ({req0_ready, req1_ready, dp_load, dp_sel} !== 4'b1010) begin
            errors++;
            $display("FAIL single_grant: got r0/r1/load/sel=%b want 1010", {req0_ready, req1_ready, dp_load, dp_sel});
        end
        cyc();
        req0_valid = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            mid();
            checks++;
            if (dp_stage_en !== (3'b001 << k) || rsp_valid !== 1'b0 || busy !== 1'b1 || dp_load !== 1'b0) begin
                errors++;
                $display("FAIL single_stage%0d: got en=%b rsp_valid=%b busy=%b load=%b want en=%b 0 1 0",
                         k, dp_stage_en, rsp_valid, busy, dp_load, 3'b001 << k);
            end
            cyc();
        end
        mid();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_tag !== 4'd5 || dp_stage_en !== 3'b000) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b id=%b tag=%0d en=%b want 1 0 5 000",
                     rsp_valid, rsp_id, rsp_tag, dp_stage_en);
        end
        cyc();
        mid();
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic exp_id;
        do_reset();
        req0_valid = 1'b1; req0_tag = 4'd3;
        req1_valid = 1'b1; req1_tag = 4'd9;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_id = (i % 2 == 1);
            mid();
            checks++;
            if (req0_ready !== !exp_id || req1_ready !== exp_id || dp_sel !== exp_id) begin
                errors++;
                $display("FAIL rr_grant%0d: got r0=%b r1=%b sel=%b want grant to %0d",
                         i, req0_ready, req1_ready, dp_sel, exp_id);
            end
            cyc(); cyc(); cyc(); cyc();
            mid();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_tag !== (exp_id ? 4'd9 : 4'd3)
                || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL rr_rsp%0d: got valid=%b id=%b tag=%0d r0=%b r1=%b want 1 %0d %0d 0 0",
                         i, rsp_valid, rsp_id, rsp_tag, req0_ready, req1_ready, exp_id, exp_id ? 9 : 3);
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_hold();
        req0_valid = 1'b1; req0_tag = 4'd7; rsp_ready = 1'b0;
        mid();
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_grant: got r0=%b want 1", req0_ready);
        end
        cyc();
        req1_valid = 1'b1; req1_tag = 4'd1;
        cyc(); cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            mid();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_tag !== 4'd7 || rsp_id !== 1'b0
                || req0_ready !== 1'b0 || req1_ready !== 1'b0 || dp_stage_en !== 3'b000) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b tag=%0d id=%b r0=%b r1=%b en=%b want 1 7 0 0 0 000",
                         i, rsp_valid, rsp_tag, rsp_id, req0_ready, req1_ready, dp_stage_en);
            end
            cyc();
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        cyc();
        mid();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got busy=%b want 0", busy);
        end
        cyc();
    endtask

    task automatic test_flush_run();
        req0_valid = 1'b1; req0_tag = 4'd2;
        req1_valid = 1'b1; req1_tag = 4'd11;
        mid();
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_pre_grant: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        mid();
        checks++;
        if (dp_sel !== 1'b1 || dp_stage_en !== 3'b001) begin
            errors++;
            $display("FAIL flush_run_t1: got sel=%b en=%b want 1 001", dp_sel, dp_stage_en);
        end
        cyc();
        flush = 1'b1;
        mid();
        checks++;
        if (dp_stage_en !== 3'b000 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got en=%b rsp_valid=%b want 000 0", dp_stage_en, rsp_valid);
        end
        cyc();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mid();
            checks++;
            if (busy !== 1'b0 || rsp_valid !== 1'b0 || dp_stage_en !== 3'b000) begin
                errors++;
                $display("FAIL flush_after%0d: got busy=%b rsp_valid=%b en=%b want 0 0 000",
                         i, busy, rsp_valid, dp_stage_en);
            end
            cyc();
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        mid();
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_rr_kept: got r0=%b r1=%b want 0 1", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); cyc(); cyc();
        mid();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_tag !== 4'd11) begin
            errors++;
            $display("FAIL flush_next_rsp: got valid=%b id=%b tag=%0d want 1 1 11", rsp_valid, rsp_id, rsp_tag);
        end
        cyc();
    endtask

    task automatic test_flush_idle();
        flush = 1'b1; req1_valid = 1'b1; req1_tag = 4'd6;
        mid();
        checks++;
        if (req1_ready !== 1'b0 || dp_load !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle: got r1=%b load=%b want 0 0", req1_ready, dp_load);
        end
        cyc();
        flush = 1'b0; req1_valid = 1'b0;
        mid();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_busy: got busy=%b want 0", busy);
        end
        cyc();
    endtask

    task automatic test_reset_done();
        req1_valid = 1'b1; req1_tag = 4'd4; rsp_ready = 1'b0;
        mid();
        checks++;
        if (req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstdone_grant: got r1=%b want 1", req1_ready);
        end
        cyc();
        req1_valid = 1'b0;
        cyc(); cyc(); cyc();
        mid();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_tag !== 4'd4 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL rstdone_pre: got valid=%b tag=%0d id=%b want 1 4 1", rsp_valid, rsp_tag, rsp_id);
        end
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        mid();
        checks++;
        if ({req0_ready, req1_ready, dp_load, dp_sel, dp_stage_en, rsp_valid, rsp_id, rsp_tag, busy} !== '0) begin
            errors++;
            $display("FAIL rstdone_outputs: got %b want all zero",
                     {req0_ready, req1_ready, dp_load, dp_sel, dp_stage_en, rsp_valid, rsp_id, rsp_tag, busy});
        end
        cyc();
        req0_valid = 1'b1; req1_valid = 1'b1;
        mid();
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstdone_rr: got r0=%b r1=%b want 1 0", req0_ready, req1_ready);
        end
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_flush_run();
        test_flush_idle();
        test_reset_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
